// File: rtl/fifo_demux_out_if.sv
// Handshake/data bundle between a demux lane, its output FIFO and the downstream stage.
interface fifo_demux_out_if #(
  parameter int unsigned DATA_WIDTH = 10,
  parameter int unsigned ADDR_WIDTH = 2
);
  logic                  push;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  pop;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  error;

  modport master (
    output push, data_in, pop,
    input  data_out, valid_out, full, empty, almost_full, almost_empty, count, error
  );

  modport slave (
    input  push, data_in, pop,
    output data_out, valid_out, full, empty, almost_full, almost_empty, count, error
  );
endinterface

// File: rtl/fifo_demux_out.sv
// Per-lane synchronous FIFO behind the 1:2 demux, with occupancy flags and an access-error flag.
// Define FIFO_STICKY_ERR_EN to make error latch until reset instead of pulsing.
module fifo_demux_out #(
  parameter int unsigned DATA_WIDTH = 10,
  parameter int unsigned ADDR_WIDTH = 2,
  parameter int unsigned AF_TH      = 3,
  parameter int unsigned AE_TH      = 1
) (
  input  logic            clk,
  input  logic            reset,
  fifo_demux_out_if.slave bus
);
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CW    = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [CW-1:0]         count_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q;
  logic                  error_q;

  logic full_c;
  logic empty_c;
  logic rd_ok_c;
  logic wr_ok_c;
  logic err_ev_c;

  // Flags decode the registered occupancy only, so no input reaches an output.
  assign full_c  = (count_q == CW'(DEPTH));
  assign empty_c = (count_q == '0);

  // A pop on a full FIFO frees the slot a simultaneous push needs.
  assign rd_ok_c  = bus.pop && !empty_c;
  assign wr_ok_c  = bus.push && (!full_c || rd_ok_c);
  assign err_ev_c = (bus.push && full_c && !bus.pop) || (bus.pop && empty_c);

  // Storage has no reset; stale words are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (wr_ok_c) mem[wr_ptr] <= bus.data_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      valid_q <= rd_ok_c;
      if (wr_ok_c) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (rd_ok_c) begin
        rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
        data_q <= mem[rd_ptr];
      end
      case ({wr_ok_c, rd_ok_c})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
`ifdef FIFO_STICKY_ERR_EN
      error_q <= error_q | err_ev_c;
`else
      error_q <= err_ev_c;
`endif
    end
  end

  assign bus.data_out     = data_q;
  assign bus.valid_out    = valid_q;
  assign bus.count        = count_q;
  assign bus.full         = full_c;
  assign bus.empty        = empty_c;
  assign bus.almost_full  = (count_q >= CW'(AF_TH));
  assign bus.almost_empty = (count_q <= CW'(AE_TH));
  assign bus.error        = error_q;
endmodule

// File: doc/fifo_demux_out.md
Name: fifo_demux_out

Overview:
- Synchronous FIFO that sits directly downstream of the 1:2 demux.
- One instance per demux output lane: the demux's push_x/outx drive this block's push/data_in.
- Buffers 10-bit words until the next stage pops them, and provides full/empty, threshold flags and an error flag for flow control toward the upstream classifier.

Parameters:
- DATA_WIDTH, 10, word width; must match the demux lane width.
- ADDR_WIDTH, 2, pointer width; depth = 2**ADDR_WIDTH = 4 entries.
- AF_TH, 3, almost_full asserts when count >= AF_TH.
- AE_TH, 1, almost_empty asserts when count <= AE_TH.

Ports:
- clk  input  1  rising-edge clock for all state.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- push  input  1  write strobe; data_in is captured on the edge where push=1.
- data_in  input  DATA_WIDTH  write data.
- pop  input  1  read strobe.
- data_out  output  DATA_WIDTH  registered read data.
- valid_out  output  1  high for exactly one cycle after an accepted pop; qualifies data_out.
- full  output  1  count == 2**ADDR_WIDTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AF_TH.
- almost_empty  output  1  count <= AE_TH.
- count  output  ADDR_WIDTH+1  current occupancy, 0 to 2**ADDR_WIDTH.
- error  output  1  illegal access indicator; see Behaviour.

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset is asynchronous and active-high on the port named reset.
  - While reset=1: wr_ptr=0, rd_ptr=0, count=0, data_out=0, valid_out=0, error=0.
  - Reset values of the flags: empty=1, full=0, almost_empty=1, almost_full=0.
  - Memory contents are not cleared and are don't-care.
- Storage: DATA_WIDTH x 2**ADDR_WIDTH register array. Pointers are ADDR_WIDTH bits and wrap modulo depth (3 -> 0).
- Accepted write: push=1 and (not full, or pop accepted in the same cycle).
  - mem[wr_ptr] <= data_in; wr_ptr increments.
- Accepted read: pop=1 and not empty.
  - data_out <= mem[rd_ptr]; rd_ptr increments; valid_out <= 1 next cycle.
  - When no read is accepted: valid_out <= 0 and data_out holds its last value.
- Latency:
  - Push-to-visible: pushing in cycle N lets empty deassert and count update at edge N+1.
  - Read: pop accepted at edge N gives data_out/valid_out valid after edge N.
  - Read-under-write of the same location does not occur, because reads require not-empty.
- count: +1 on write only, -1 on read only, unchanged on both or neither. All flags are combinational decodes of registered count.
- Simultaneous push and pop:
  - Empty: pop rejected (error), push accepted; count 0 -> 1.
  - Full: both accepted; count stays 4, pointers both advance, no error.
  - Otherwise: both accepted; count unchanged.
- Overflow: push=1, full=1, pop=0 -> write dropped, pointers unchanged, error=1 for that following cycle.
- Underflow: pop=1, empty=1 -> read dropped, valid_out=0, error=1 for the following cycle.
- Without FIFO_STICKY_ERR_EN, error is a one-cycle pulse per offending edge.
- Reset mid-operation: all pointers and count clear asynchronously. Stored words are discarded, and the first pop after reset sees empty.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro: FIFO_STICKY_ERR_EN.
- Defined: error latches high on the first overflow or underflow and stays high until reset, so the tester can detect errors at end of test.
- Undefined: error is the one-cycle pulse described above.
- FIFO data behaviour is identical in both builds.

Test Plan:
- Reset then idle -> empty=1, almost_empty=1, full=0, count=0, data_out=0, valid_out=0, error=0.
- Push 0x3A1, 0x015, 0x2FF, 0x100 on four consecutive cycles -> count 1,2,3,4; almost_full at count=3; full=1 after the 4th; then pop x4 -> data_out 0x3A1, 0x015, 0x2FF, 0x100 with valid_out high each cycle; empty=1 at end.
- Full FIFO, push 0x0AA with pop=0 -> count stays 4, error pulses one cycle; subsequent pops return the original four words, never 0x0AA.
- Empty FIFO, push 0x155 and pop together -> valid_out=0, error=1, count=1; next pop returns 0x155.
- Full FIFO, push 0x077 and pop together for 6 cycles -> count stays 4, no error, output order continuous across pointer wrap.
- Push 2 words, assert reset asynchronously mid-cycle -> count=0 and empty=1 immediately, without waiting for a clk edge. With FIFO_STICKY_ERR_EN, an earlier underflow keeps error=1 until this reset clears it.
